// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to build the fetch starvation guard (streak counter).
module mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_dmtype,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_dmtype,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    state_e        state_q;
    owner_e        owner_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [2:0]    mem_dmtype_q;
    logic          i_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          data_wins;

    if (STREAK_MAX < 1) begin : g_bad_streak_max
        $error("mem_arbiter: STREAK_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STREAK_MAX + 1);

    logic [SW-1:0] streak_q;

    // Fetch takes the port once data has won STREAK_MAX times in a row over it.
    always_comb begin
        data_wins = d_req && !(i_req && (streak_q == SW'(STREAK_MAX)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else if ((state_q == S_IDLE) && (i_req || d_req)) begin
            if (!data_wins || !i_req) begin
                streak_q <= '0;
            end else if (streak_q != SW'(STREAK_MAX)) begin
                streak_q <= streak_q + SW'(1);
            end
        end
    end
`else
    assign data_wins = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_dmtype_q <= 3'b000;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            // NOTE: acks default low every cycle so a completion can only ever pulse once.
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state_q   <= S_BUSY;
                        mem_req_q <= 1'b1;
                        if (data_wins) begin
                            owner_q      <= OWN_D;
                            mem_we_q     <= d_we;
                            mem_addr_q   <= d_addr;
                            mem_wdata_q  <= d_wdata;
                            mem_dmtype_q <= d_dmtype;
                        end else begin
                            owner_q      <= OWN_I;
                            mem_we_q     <= 1'b0;
                            mem_addr_q   <= i_addr;
                            mem_wdata_q  <= '0;
                            mem_dmtype_q <= 3'b000;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        if (owner_q == OWN_I) begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // No grant here, so a request still high during its own ack is not re-served.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_dmtype = mem_dmtype_q;
    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign stall_if   = i_req & ~i_ack_q;
    assign stall_mem  = d_req & ~d_ack_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the pipelined core's single unified memory port between instruction fetch (IF) and data access (MEM stage).
- Serialises transactions through a three-state FSM with registered outputs.
- Returns one-cycle acknowledge pulses with captured read data.
- Generates the per-stage stall signals consumed by the pipeline hazard logic.
- Data accesses have priority; an optional starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STREAK_MAX, 4, maximum consecutive data grants while fetch waits (guard only, ≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DW  fetched word, valid when i_ack=1
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_dmtype  in  3  access type, passed through unchanged (same DMType encoding as the control unit)
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid when d_ack=1
- mem_req  out  1  memory request, held high until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_dmtype  out  3  memory access type
- mem_ready  in  1  memory completion, sampled only in BUSY
- mem_rdata  in  DW  memory read data, valid with mem_ready
- stall_if  out  1  = i_req & ~i_ack
- stall_mem  out  1  = d_req & ~d_ack

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Owner register: I or D, records the current grant.
- IDLE:
  - If any request is present, pick a winner. Register its address, data, we and dmtype into the mem_* output registers, set the owner, and go to BUSY.
  - Fetch grants drive mem_we=0 and mem_dmtype=3'b000.
  - No request: stay in IDLE.
- BUSY:
  - mem_req=1 with all mem_* outputs held stable.
  - On mem_ready=1, capture mem_rdata and go to DONE.
  - Otherwise stay in BUSY; there is no timeout.
- DONE:
  - Pulse the owner's ack for exactly one cycle.
  - Fetch: i_rdata = captured data. Load: d_rdata = captured data. Store: d_rdata keeps its previous value.
  - Return to IDLE. No new grant is made in this cycle, so a request still asserted during its own ack is never granted twice.
- Priority: when both requests are present in IDLE, data wins, except under the starvation guard (see Configuration).
- A request deasserted while BUSY is a protocol violation. The transaction still completes and ack still pulses.
- i_rdata and d_rdata hold their values between acks.
- stall_if and stall_mem are combinational from req and ack.

## Timing
- Reset values: state IDLE, owner I, streak 0; mem_req, mem_we, i_ack and d_ack 0; mem_addr, mem_wdata, mem_dmtype, i_rdata and d_rdata all 0.
- Reset asserted mid-transaction forces IDLE immediately, mem_req drops asynchronously, and no ack is issued.
- Request sampled in cycle N:
  - mem_req high from N+1.
  - mem_ready in cycle M ≥ N+1 gives ack in M+1.
  - The next grant is possible in M+2.
- Minimum 3 cycles per transaction.
- Back-to-back requests from the same source: request in N, ack in N+2, next grant decided in N+3.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A streak counter increments on every data grant made while i_req=1.
  - It clears on a fetch grant, and on a data grant made with i_req=0.
  - If both requests are present and streak==STREAK_MAX, fetch wins.
  - The counter saturates at STREAK_MAX.
- Undefined: no counter is built and data always wins.

## Test plan
- Single fetch, i_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0x00A00093 -> mem_req high in cycle 1, i_ack in cycle 3 with i_rdata=0x00A00093, stall_if high in cycles 0-2.
- Store d_addr=0x40, d_wdata=0xDEADBEEF, d_dmtype=3'b011, mem_ready delayed 4 cycles -> mem_we=1, mem_dmtype=3'b011 and address/data held stable throughout BUSY; d_ack once; d_rdata unchanged.
- i_req and d_req asserted together and held continuously, guard undefined -> data is granted every time and i_ack never pulses.
- Same stimulus, guard defined, STREAK_MAX=4 -> four data grants, then one fetch grant, then the pattern repeats.
- rst pulsed while BUSY with mem_ready=0 -> mem_req=0 immediately, no ack, next grant follows the priority rule from IDLE.
- mem_ready=1 asserted while in IDLE -> ignored: no state change and no ack.
